divisor_sequencial: RTL and testbench

DIVISOR_SEQUENCIAL -- requirements
Module: divisor_sequencial

---
 rtl/divisor_sequencial_if.sv | 24 ++
 rtl/divisor_sequencial.sv | 138 +++++++++++++
 tb/tb_divisor_sequencial.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/divisor_sequencial_if.sv
// Operand/result bundle for divisor_sequencial: the master drives operands and Start,
// the slave (the divider) returns quotient, remainder and status.
interface divisor_sequencial_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] Dividendo;
    logic [WIDTH-1:0] Divisor;
    logic             Start;
    logic [WIDTH-1:0] Quociente;
    logic [WIDTH-1:0] Resto;
    logic             Pronto;
    logic             Ocupado;
    logic             DivZero;

    modport master (
        output Dividendo, Divisor, Start,
        input  Quociente, Resto, Pronto, Ocupado, DivZero
    );

    modport slave (
        input  Dividendo, Divisor, Start,
        output Quociente, Resto, Pronto, Ocupado, DivZero
    );
endinterface

// File: rtl/divisor_sequencial.sv
// Unsigned restoring shift-subtract divider producing one quotient bit per cycle, MSB first.
// Define DIVISOR_DIVZERO_EN to short-circuit a zero divisor in a single cycle and flag DivZero.
module divisor_sequencial #(
    parameter int WIDTH = 16
) (
    input logic                 Clk,
    input logic                 Reset,
    divisor_sequencial_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quociente_q, quociente_d;
    logic [WIDTH-1:0] resto_q, resto_d;
    logic             pronto_q, pronto_d;
    logic             ocupado;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             sub;
`ifdef DIVISOR_DIVZERO_EN
    logic             divzero_q, divzero_d;
`endif

    // The remainder never exceeds the divisor, so a set top bit already means "subtract".
    always_comb begin
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dsr_q};
        sub     = rem_q[WIDTH] | (shifted >= {1'b0, dsr_q});
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            quociente_q <= '0;
            resto_q     <= '0;
            pronto_q    <= 1'b0;
`ifdef DIVISOR_DIVZERO_EN
            divzero_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            quociente_q <= quociente_d;
            resto_q     <= resto_d;
            pronto_q    <= pronto_d;
`ifdef DIVISOR_DIVZERO_EN
            divzero_q   <= divzero_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
`ifdef DIVISOR_DIVZERO_EN
                    state_d = (bus.Divisor == '0) ? DONE : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        quociente_d = quociente_q;
        resto_d     = resto_q;
        pronto_d    = 1'b0;
        ocupado     = (state_q == CALC);
`ifdef DIVISOR_DIVZERO_EN
        divzero_d   = divzero_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    rem_d = '0;
                    quo_d = bus.Dividendo;
                    dsr_d = bus.Divisor;
                    cnt_d = CW'(WIDTH - 1);
`ifdef DIVISOR_DIVZERO_EN
                    if (bus.Divisor == '0) begin
                        quociente_d = '1;
                        resto_d     = bus.Dividendo;
                        divzero_d   = 1'b1;
                        pronto_d    = 1'b1;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = sub ? diff : shifted;
                quo_d = {quo_q[WIDTH-2:0], sub};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quociente_d = {quo_q[WIDTH-2:0], sub};
                    resto_d     = sub ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    pronto_d    = 1'b1;
`ifdef DIVISOR_DIVZERO_EN
                    divzero_d   = 1'b0;
`endif
                end
            end
            default: ;
        endcase
    end

    assign bus.Quociente = quociente_q;
    assign bus.Resto     = resto_q;
    assign bus.Pronto    = pronto_q;
    assign bus.Ocupado   = ocupado;
`ifdef DIVISOR_DIVZERO_EN
    assign bus.DivZero   = divzero_q;
`else
    assign bus.DivZero   = 1'b0;
`endif
endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial: directed vector table, hand-built corner
// sequences (ignored Start, mid-run reset) and a short random sweep against / and %.
module tb_divisor_sequencial;
    localparam int W = 16;
`ifdef DIVISOR_DIVZERO_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    divisor_sequencial_if #(.WIDTH(W)) bus ();

    divisor_sequencial #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Present operands with Start for exactly one rising edge (T0); returns just after T0.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clk);
        bus.Dividendo = a;
        bus.Divisor   = b;
        bus.Start     = 1'b1;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
    endtask

    task automatic waitDone(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        while (!bus.Pronto && lat < 40) begin
            busy += int'(bus.Ocupado);
            @(posedge Clk);
            #1;
            lat++;
        end
        if (!bus.Pronto) checkOutput("pronto_timeout", 0, 1);
    endtask

    task automatic runOne(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r, input bit full);
        int lat, busy, expLat;
        bit zeroShort;
        zeroShort = ZEN && (b == '0);
        expLat    = zeroShort ? 0 : W;
        applyStimulus(a, b);
        waitDone(lat, busy);
        checkOutput({name, "_quociente"}, bus.Quociente, q);
        checkOutput({name, "_resto"}, bus.Resto, r);
        if (full) begin
            checkOutput({name, "_divzero"}, bus.DivZero, zeroShort ? 1 : 0);
            checkOutput({name, "_latency"}, lat, expLat);
            checkOutput({name, "_busy_cycles"}, busy, expLat);
        end
        @(posedge Clk);
        #1;
        checkOutput({name, "_pronto_cleared"}, bus.Pronto, 0);
        if (full) checkOutput({name, "_idle_after"}, bus.Ocupado, 0);
    endtask

    initial begin
        int prontoCount;
        logic [W-1:0] capQ, capR;
        logic [W-1:0] ra, rb;

        vecs[0] = '{a: 16'd100,   b: 16'd7,     q: 16'd14,    r: 16'd2};
        vecs[1] = '{a: 16'd65535, b: 16'd1,     q: 16'd65535, r: 16'd0};
        vecs[2] = '{a: 16'd5,     b: 16'd9,     q: 16'd0,     r: 16'd5};
        vecs[3] = '{a: 16'd1234,  b: 16'd0,     q: 16'hFFFF,  r: 16'd1234};
        vecs[4] = '{a: 16'd0,     b: 16'd5,     q: 16'd0,     r: 16'd0};
        vecs[5] = '{a: 16'd65535, b: 16'd65535, q: 16'd1,     r: 16'd0};
        vecs[6] = '{a: 16'd65534, b: 16'd65535, q: 16'd0,     r: 16'd65534};
        vecs[7] = '{a: 16'd40000, b: 16'd256,   q: 16'd156,   r: 16'd64};
        vecs[8] = '{a: 16'd1000,  b: 16'd3,     q: 16'd333,   r: 16'd1};

        bus.Dividendo = '0;
        bus.Divisor   = '0;
        bus.Start     = 1'b0;

        #2;
        checkOutput("reset_quociente", bus.Quociente, 0);
        checkOutput("reset_resto", bus.Resto, 0);
        checkOutput("reset_pronto", bus.Pronto, 0);
        checkOutput("reset_ocupado", bus.Ocupado, 0);
        checkOutput("reset_divzero", bus.DivZero, 0);
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            runOne($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b1);
        end

        // A second Start mid-run with new operands must be dropped; results from vec8 hold.
        applyStimulus(16'd100, 16'd7);
        repeat (4) @(posedge Clk);
        #1;
        checkOutput("hold_quociente_in_calc", bus.Quociente, 333);
        checkOutput("hold_resto_in_calc", bus.Resto, 1);
        bus.Dividendo = 16'd50;
        bus.Divisor   = 16'd5;
        bus.Start     = 1'b1;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        prontoCount = 0;
        capQ = '0;
        capR = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge Clk);
            #1;
            if (bus.Pronto) begin
                prontoCount++;
                capQ = bus.Quociente;
                capR = bus.Resto;
            end
        end
        checkOutput("ignore_pronto_pulses", prontoCount, 1);
        checkOutput("ignore_quociente", capQ, 14);
        checkOutput("ignore_resto", capR, 2);

        // Asynchronous reset between edges in the middle of a division.
        applyStimulus(16'd100, 16'd7);
        repeat (7) @(posedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        checkOutput("midreset_ocupado", bus.Ocupado, 0);
        checkOutput("midreset_quociente", bus.Quociente, 0);
        checkOutput("midreset_resto", bus.Resto, 0);
        checkOutput("midreset_pronto", bus.Pronto, 0);
        @(negedge Clk);
        Reset = 1'b1;
        prontoCount = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge Clk);
            #1;
            if (bus.Pronto) prontoCount++;
        end
        checkOutput("midreset_no_pronto", prontoCount, 0);
        checkOutput("midreset_still_idle", bus.Ocupado, 0);
        runOne("after_reset", 16'd200, 16'd3, 16'd66, 16'd2, 1'b1);

        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = W'($urandom_range(1, 65535));
            if (i % 4 == 0) rb = W'($urandom_range(1, 255));
            runOne($sformatf("rand%0d", i), ra, rb, ra / rb, ra % rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
